// File: rtl/mode_sequencer_if.sv
// Mode sequencer bus: mode requests and enables in, current mode and status out.
interface mode_sequencer_if #(
    parameter int NUM_MODES = 3,
    parameter int IDX_W     = $clog2(NUM_MODES)
);
    logic [NUM_MODES-1:0] sel_i;
    logic                 adv_i;
    logic                 dir_i;
    logic [NUM_MODES-1:0] mode_en_i;
    logic [NUM_MODES-1:0] state_o;
    logic [IDX_W-1:0]     mode_idx_o;
    logic                 changed_o;
    logic                 busy_o;

    modport master (
        output sel_i, adv_i, dir_i, mode_en_i,
        input  state_o, mode_idx_o, changed_o, busy_o
    );

    modport slave (
        input  sel_i, adv_i, dir_i, mode_en_i,
        output state_o, mode_idx_o, changed_o, busy_o
    );
endinterface

// File: rtl/mode_sequencer.sv
// One-hot operating mode register with direct select, edge-triggered advance
// with hold-off, and forward eviction out of disabled modes.
module mode_sequencer #(
    parameter int NUM_MODES      = 3,
    parameter int RESET_MODE     = 0,
    parameter int HOLDOFF_CYCLES = 1000,
    parameter int IDX_W          = $clog2(NUM_MODES)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mode_sequencer_if.slave    bus
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    // Nearest enabled mode other than cur, stepping backward when back=1.
    // Result MSB flags whether such a mode exists.
    function automatic logic [IDX_W:0] find_next(input logic [IDX_W-1:0] cur,
                                                 input logic back,
                                                 input logic [NUM_MODES-1:0] en);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        // Walk from the farthest candidate inward so the nearest one wins.
        for (int k = NUM_MODES - 1; k >= 1; k--) begin
            if (back) idx = (int'(cur) - k + NUM_MODES) % NUM_MODES;
            else      idx = (int'(cur) + k) % NUM_MODES;
            if (en[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    logic                 adv_q;
    logic [CNT_W-1:0]     hold_cnt;
    logic                 adv_acc;
    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W:0]       adv_tgt;
    logic [IDX_W:0]       evict_tgt;
    logic [IDX_W-1:0]     next_idx;
    logic [CNT_W-1:0]     cnt_next;

    // Next-mode decision: accepted advance beats valid select beats eviction.
    always_comb begin
        adv_acc   = bus.adv_i & ~adv_q & ~bus.busy_o;
        sel_idx   = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (bus.sel_i[i]) sel_idx = IDX_W'(i);
        end
        sel_valid = (bus.sel_i != '0)
                  && ((bus.sel_i & (bus.sel_i - NUM_MODES'(1))) == '0)
                  && ((bus.sel_i & bus.mode_en_i) != '0)
                  && (bus.sel_i != bus.state_o);
        adv_tgt   = find_next(bus.mode_idx_o, bus.dir_i, bus.mode_en_i);
        evict_tgt = find_next(bus.mode_idx_o, 1'b0, bus.mode_en_i);

        next_idx = bus.mode_idx_o;
        if (adv_acc) begin
            if (adv_tgt[IDX_W]) next_idx = adv_tgt[IDX_W-1:0];
        end else if (sel_valid) begin
            next_idx = sel_idx;
        end else if (!bus.mode_en_i[bus.mode_idx_o] && evict_tgt[IDX_W]) begin
            next_idx = evict_tgt[IDX_W-1:0];
        end

        // Hold-off restarts on every accepted advance, even a no-op one.
        if (adv_acc)             cnt_next = CNT_W'(HOLDOFF_CYCLES);
        else if (hold_cnt != '0) cnt_next = hold_cnt - CNT_W'(1);
        else                     cnt_next = '0;
    end

    // Mode, status and edge-detect registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            adv_q          <= 1'b1;
            hold_cnt       <= '0;
            bus.busy_o     <= 1'b0;
            bus.state_o    <= NUM_MODES'(1) << RESET_MODE;
            bus.mode_idx_o <= IDX_W'(RESET_MODE);
            bus.changed_o  <= 1'b0;
        end else begin
            adv_q          <= bus.adv_i;
            hold_cnt       <= cnt_next;
            bus.busy_o     <= (cnt_next != '0);
            bus.state_o    <= NUM_MODES'(1) << next_idx;
            bus.mode_idx_o <= next_idx;
            bus.changed_o  <= (next_idx != bus.mode_idx_o);
        end
    end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Parametrised successor of the board's three-mode logic controller.
- Holds a one-hot operating mode out of NUM_MODES and changes it in three ways:
  - direct push-button select;
  - edge-triggered "advance" from the clap detector, forward or backward, with hold-off;
  - automatic eviction from a mode that software or switches disable.
- Drives mode enables to the counter / LRU datapath, plus a mode-change strobe.

Parameters:
- NUM_MODES, 3, number of modes, 2..16.
- RESET_MODE, 0, mode index loaded on reset (must be < NUM_MODES).
- HOLDOFF_CYCLES, 1000, cycles after an accepted advance during which further advances are ignored. 0 disables hold-off.
- IDX_W, $clog2(NUM_MODES), width of the mode index (derived).

Ports:
- clk_i  in  1  system clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- sel_i  in  NUM_MODES  direct mode request, one bit per mode (buttons).
- adv_i  in  1  advance request, level input (clap condition); acts on rising edge.
- dir_i  in  1  advance direction: 0 = index+1, 1 = index-1, both with wrap.
- mode_en_i  in  NUM_MODES  per-mode enable mask; disabled modes are never entered.
- state_o  out  NUM_MODES  current mode, one-hot, registered.
- mode_idx_o  out  IDX_W  binary index of state_o, registered.
- changed_o  out  1  one-cycle pulse, high in the cycle after state_o took a new value.
- busy_o  out  1  hold-off active.

Behaviour:
- Reset (async assert, sync release) sets:
  - state_o = one-hot RESET_MODE, mode_idx_o = RESET_MODE;
  - changed_o = 0, busy_o = 0, hold-off counter = 0;
  - adv edge register = 1, so adv_i already high at release gives no edge.
- RESET_MODE is loaded even if mode_en_i[RESET_MODE] = 0; eviction then applies from the first cycle after release.
- Edge detect: adv_edge = adv_i & ~adv_q, where adv_q is adv_i registered each cycle.
- Advance accepted when adv_edge & ~busy_o.
  - state_o updates on the same rising edge that first samples adv_i = 1 (latency 1 clock).
- Next-mode search starts from the current index and steps in dir_i direction with modulo-NUM_MODES wrap. The target is the first enabled index other than the current one.
- If no other mode is enabled, the mode is unchanged and changed_o stays 0; the hold-off is still started.
- Hold-off counter:
  - loaded with HOLDOFF_CYCLES on an accepted advance;
  - decrements by 1 per cycle while non-zero;
  - busy_o = (counter != 0), registered;
  - edges while busy_o = 1 are dropped, not queued.
- Select valid when all of the following hold:
  - sel_i has exactly one bit set;
  - that mode is enabled;
  - it differs from the current mode.
  Otherwise (0 or ≥2 bits set, or a disabled target) sel_i is ignored. Select is not blocked by hold-off and does not start it.
- Eviction: if mode_en_i[current] = 0, move to the next enabled mode in the forward direction. If none is enabled, stay.
- Priority within one cycle: accepted advance > valid select > eviction.
  - Advance and eviction in the same cycle: the advance target is already an enabled mode.
- changed_o = registered (state_next != state_o). It never asserts without a state change.
- Invariants, checked every cycle:
  - state_o is always exactly one-hot;
  - mode_idx_o always encodes state_o;
  - no enabled-to-disabled transition is caused by advance or select.
- Changes to mode_en_i take effect combinationally in the same-cycle decision; no extra latency.
- Asserting rst_ni low mid-hold-off clears the counter and busy_o immediately.

Test Plan:
(All scenarios use NUM_MODES=4, RESET_MODE=0, HOLDOFF_CYCLES=4, mode_en_i=4'b1111 unless stated.)
- Reset with adv_i held high, release, hold adv_i high 10 cycles -> state_o stays 4'b0001, changed_o never 1, busy_o 0.
- Forward cycling:
  - stimulus: dir_i=0; adv_i pulses 0→1 spaced 6 cycles apart, 5 times;
  - state_o sequence: 0010, 0100, 1000, 0001, 0010;
  - each update lands on the edge that samples adv_i=1; changed_o is high the following cycle;
  - busy_o is high for 4 cycles after each advance.
- Hold-off:
  - stimulus: from mode 0, two adv_i edges 2 cycles apart, then a third edge 5 cycles after the first;
  - first edge -> mode 1; second edge dropped; third -> mode 2.
- Backward with skip:
  - stimulus: mode_en_i=4'b1011, current mode 0, dir_i=1, one adv edge;
  - wraps to mode 3 (4'b1000); a second edge after hold-off goes to mode 1, skipping disabled mode 2.
- Select rules:
  - stimulus: from mode 0, sel_i=4'b0110 -> ignored;
  - sel_i=4'b0100 -> mode 2 next edge, changed_o pulse;
  - sel_i=4'b0100 held -> no further pulses;
  - sel_i=4'b1000 applied together with an accepted adv edge (dir_i=0) -> mode 3 (advance from 2) wins;
  - sel_i=4'b0001 during busy -> mode 0.
- Eviction and mid-operation reset:
  - stimulus: in mode 2, drop mode_en_i[2] -> mode 3 next edge;
  - then mode_en_i=4'b1000 and an adv edge -> stays 1000, changed_o 0, busy_o 1;
  - assert rst_ni low asynchronously mid-hold-off -> outputs return to reset values without a clock edge.
